// File: rtl/pc_next_unit.sv
// pc_next_unit: MIPS program counter, next-PC select, boot/run/halt FSM.
// Optional feature macro PC_ALIGN_CHECK_EN: trap on misaligned targets.
module pc_next_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] cnt_q;
    logic        fv_q;
    logic        hl_q;
    logic [31:0] tgt_raw;
    logic [31:0] pc_d;
    logic        bad_d;

    assign pc_plus4 = pc_q + 32'd4;

    // Target mux: jr beats jump beats branch beats sequential
    always_comb begin
        tgt_raw = pc_plus4;
        if (jr) begin
            tgt_raw = jr_target;
        end else if (jump) begin
            tgt_raw = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            tgt_raw = pc_plus4 + branch_offset;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q;
    assign pc_d     = tgt_raw;
    assign bad_d    = |tgt_raw[1:0];
    assign misalign = mis_q;
`else
    assign pc_d     = tgt_raw & ~32'd3;
    assign bad_d    = 1'b0;
    assign misalign = 1'b0;
`endif

    // Boot/run/halt FSM owning pc, counter and the registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= 32'd0;
            fv_q    <= 1'b0;
            hl_q    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    fv_q    <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            cnt_q   <= cnt_q + 32'd1;
                            state_q <= HALT;
                            fv_q    <= 1'b0;
                            hl_q    <= 1'b1;
                        end else if (bad_d) begin
                            state_q <= HALT;
                            fv_q    <= 1'b0;
                            hl_q    <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                            mis_q   <= 1'b1;
`endif
                        end else begin
                            pc_q  <= pc_d;
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= BOOT;
                    fv_q    <= 1'b0;
                    hl_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign fetch_valid = fv_q;
    assign halted      = hl_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed bench with a queued expectation scoreboard.
// Honours PC_ALIGN_CHECK_EN for the misaligned-target expectations.
module tb_pc_next_unit;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, stall, halt, branch_taken, jump, jr;
    logic [31:0] branch_offset, jr_target;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4, instr_count;
    logic        fetch_valid, halted, misalign;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        fv;
        logic        hl;
        logic        mis;
    } exp_t;

    exp_t q[$];

    // reference model state: 0 BOOT, 1 RUN, 2 HALT
    int          ms;
    logic [31:0] mpc, mcnt;
    logic        mmis;

    pc_next_unit #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .jr(jr),
        .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .halted(halted),
        .misalign(misalign), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] p4, t;
        if (reset) begin
            ms = 0; mpc = RV; mcnt = 0; mmis = 0;
        end else if (ms == 0) begin
            ms = 1;
        end else if (ms == 1 && !stall) begin
            if (halt) begin
                mcnt = mcnt + 1; ms = 2;
            end else begin
                p4 = mpc + 32'd4;
                if (jr) t = jr_target;
                else if (jump) t = {p4[31:28], jump_index, 2'b00};
                else if (branch_taken) t = p4 + branch_offset;
                else t = p4;
`ifdef PC_ALIGN_CHECK_EN
                if (t[1:0] != 2'b00) begin
                    mmis = 1; ms = 2;
                end else begin
                    mpc = t; mcnt = mcnt + 1;
                end
`else
                mpc = {t[31:2], 2'b00}; mcnt = mcnt + 1;
`endif
            end
        end
    endtask

    // one clock: predict, push, clock, pop and compare
    task automatic step();
        exp_t e;
        model_edge();
        e.pc = mpc; e.cnt = mcnt; e.mis = mmis;
        e.fv = (ms == 1); e.hl = (ms == 2);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("instr_count", instr_count, e.cnt);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        chk("halted", {31'd0, halted}, {31'd0, e.hl});
        chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
    endtask

    task automatic idle();
        reset = 0; stall = 0; halt = 0; branch_taken = 0; jump = 0;
        jr = 0; branch_offset = 0; jump_index = 0; jr_target = 0;
    endtask

    task automatic do_jr(input logic [31:0] t);
        idle(); jr = 1; jr_target = t; step(); idle();
    endtask

    initial begin
        ms = 0; mpc = RV; mcnt = 0; mmis = 0;
        idle();
        reset = 1;
        step();
        chk("rst_pc", pc, RV);
        chk("rst_pp4", pc_plus4, RV + 32'd4);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        reset = 0;
        step();
        chk("run_pc0", pc, 32'h0040_0000);
        chk("run_fv", {31'd0, fetch_valid}, 32'd1);
        step();
        chk("seq_pc1", pc, 32'h0040_0004);
        step();
        chk("seq_pc2", pc, 32'h0040_0008);
        chk("seq_cnt", instr_count, 32'd2);

        do_jr(32'h100);
        branch_taken = 1; branch_offset = 32'hFFFF_FFF0;
        step(); idle();
        chk("branch_back", pc, 32'h0000_00F4);
        do_jr(32'h100);
        branch_taken = 1; branch_offset = 32'hFFFF_FFF0;
        jump = 1; jump_index = 26'h10;
        step(); idle();
        chk("jump_over_br", pc, 32'h0000_0040);

        stall = 1; jr = 1; jr_target = 32'h2000;
        for (int i = 0; i < 3; i++) step();
        chk("stall_pc", pc, 32'h0000_0040);
        stall = 0;
        step(); idle();
        chk("jr_after", pc, 32'h0000_2000);

        do_jr(32'hFFFF_FFFC);
        step();
        chk("wrap_pc", pc, 32'h0000_0000);

        reset = 1; step(); reset = 0; step();
        for (int i = 0; i < 5; i++) do_jr(32'h20);
        chk("pre_halt_cnt", instr_count, 32'd5);
        halt = 1; step(); idle();
        chk("halt_hl", {31'd0, halted}, 32'd1);
        chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
        chk("halt_pc", pc, 32'h20);
        chk("halt_cnt", instr_count, 32'd6);
        jump = 1; jump_index = 26'h3FF;
        step(); step(); idle();
        chk("halt_hold", pc, 32'h20);
        reset = 1; step(); reset = 0;
        chk("halt_rst", pc, RV);

        step();
        do_jr(32'h2002);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc", pc, RV);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_hl", {31'd0, halted}, 32'd1);
`else
        chk("mis_pc", pc, 32'h2000);
        chk("mis_flag", {31'd0, misalign}, 32'd0);
`endif

        reset = 1; step(); reset = 0; step();
        do_jr(32'h300);
        stall = 1; step(); reset = 1; step();
        idle();
        chk("rst_stall_pc", pc, RV);
        chk("rst_stall_fv", {31'd0, fetch_valid}, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
